// File: rtl/line_window_ctrl.sv
// Sequencer for the 3x3 line-buffer window of the mean filter: accepts a raster pixel stream,
// strobes the buffer, tracks window centre/border and flushes the tail. Option: LWC_FEEDBACK_EN.
module line_window_ctrl #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          pad_zero,
  output logic          win_valid,
  output logic [CW-1:0] ctr_col,
  output logic [CW-1:0] ctr_row,
  output logic          border,
  output logic          feed_sel,
  output logic          busy,
  output logic          frame_done,
  output logic [1:0]    state_dbg
);

  // Handshake: a pixel moves when in_valid & in_ready in the same cycle; in_ready never
  // depends on in_valid, and the source must hold its pixel until it is accepted.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ROW_END  = CW'(IMG_H + 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] in_col;
  logic [CW-1:0] in_row;
  logic          accept;
  logic          col_wrap;
  logic          last_flush;
  logic          window_hit;
  logic [CW-1:0] c_col;
  logic [CW-1:0] c_row;
  logic          c_border;

  assign state_dbg = state;
  assign busy      = (state != IDLE);
  assign col_wrap  = (in_col == COL_LAST);
  // Flush shifts run k = IMG_W*IMG_H .. IMG_W*(IMG_H+1); only the last lands on row IMG_H+1.
  assign last_flush = (state == FLUSH) && (in_row == ROW_END);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    pad_zero   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_row == TWO) && (in_col == ONE)) state_next = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && (in_row == ROW_LAST) && col_wrap) state_next = FLUSH;
      end
      FLUSH: begin
        pad_zero = 1'b1;
        if (last_flush) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign shift_en   = accept | pad_zero;
  assign window_hit = shift_en && ((state == RUN) || (state == FLUSH));

  // Centre trails the incoming pixel by IMG_W+1 positions.
  always_comb begin
    c_col = in_col - ONE;
    c_row = in_row - ONE;
    if (in_col == '0) begin
      c_col = COL_LAST;
      c_row = in_row - TWO;
    end
    c_border = (c_col == '0) || (c_col == COL_LAST) || (c_row == '0) || (c_row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters sit at zero while idle so a new frame always starts from pixel 0.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      in_col <= '0;
      in_row <= '0;
    end else if (shift_en) begin
      if (col_wrap) begin
        in_col <= '0;
        in_row <= in_row + ONE;
      end else begin
        in_col <= in_col + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      border     <= 1'b0;
      frame_done <= 1'b0;
      ctr_col    <= '0;
      ctr_row    <= '0;
    end else begin
      win_valid  <= window_hit;
      border     <= window_hit & c_border;
      frame_done <= last_flush;
      if (window_hit) begin
        ctr_col <= c_col;
        ctr_row <= c_row;
      end
    end
  end

`ifdef LWC_FEEDBACK_EN
  // Only interior centres take the filtered value back into the centre-row tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      feed_sel <= 1'b0;
    end else begin
      feed_sel <= window_hit & ~c_border;
    end
  end
`else
  assign feed_sel = 1'b0;
`endif

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl (IMG_W=8, IMG_H=4) against a shift-count model.
module tb_line_window_ctrl;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int CW   = 5;
  localparam int NPIX = W * H;
  localparam int NWIN = W * H - W - 1;
`ifdef LWC_FEEDBACK_EN
  localparam int NFEED = (W - 2) * (H - 2);
`else
  localparam int NFEED = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          shift_en;
  logic          pad_zero;
  logic          win_valid;
  logic [CW-1:0] ctr_col;
  logic [CW-1:0] ctr_row;
  logic          border;
  logic          feed_sel;
  logic          busy;
  logic          frame_done;
  logic [1:0]    state_dbg;

  line_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .pad_zero(pad_zero), .win_valid(win_valid), .ctr_col(ctr_col),
    .ctr_row(ctr_row), .border(border), .feed_sel(feed_sel), .busy(busy),
    .frame_done(frame_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: a frame is just a count of shifts done since start.
  bit m_active = 1'b0;
  int m_k = 0;
  bit e_wv, e_fd, e_border, e_feed;
  logic [15:0] exp_q[$];
  int dut_wins, dut_fd, dut_pads, dut_feeds;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v);
    bit exp_ready, exp_pad, shift, was_active;
    int c, col, row;
    logic [15:0] got;
    logic [15:0] want;
    rst = r;
    start = s;
    in_valid = v;
    #1;
    exp_pad   = m_active && (m_k >= NPIX);
    exp_ready = m_active && (m_k < NPIX);
    shift     = exp_pad || (exp_ready && v);
    check("in_ready", in_ready, exp_ready);
    check("shift_en", shift_en, shift);
    check("pad_zero", pad_zero, exp_pad);
    check("busy", busy, m_active);
    if (pad_zero) dut_pads++;
    @(posedge clk);
    e_wv = 0; e_fd = 0; e_border = 0; e_feed = 0;
    was_active = m_active;
    if (r) begin
      m_active = 0;
      m_k = 0;
      exp_q.delete();
    end else begin
      if (shift) begin
        if (m_k >= 2 * W + 2) begin
          c = m_k - W - 1;
          col = c % W;
          row = c / W;
          e_wv = 1;
          e_border = (col == 0) || (col == W - 1) || (row == 0) || (row == H - 1);
          exp_q.push_back({8'(row), 8'(col)});
        end
        if (m_k == NPIX + W) begin
          e_fd = 1;
          m_active = 0;
        end
        m_k++;
      end
      if (!was_active && s) begin
        m_active = 1;
        m_k = 0;
      end
    end
`ifdef LWC_FEEDBACK_EN
    e_feed = e_wv && !e_border;
`endif
    #1;
    check("win_valid", win_valid, e_wv);
    check("frame_done", frame_done, e_fd);
    check("border", border, e_border);
    check("feed_sel", feed_sel, e_feed);
    if (feed_sel) dut_feeds++;
    if (frame_done) begin
      dut_fd++;
      check("last_col", ctr_col, W - 1);
      check("last_row", ctr_row, H - 1);
    end
    if (win_valid) begin
      dut_wins++;
      got = {8'(ctr_row), 8'(ctr_col)};
      if (exp_q.size() == 0) begin
        check("centre_unexpected", got, 16'hffff);
      end else begin
        want = exp_q.pop_front();
        check("centre", got, want);
      end
      if (dut_wins == 1) check("first_centre", got, {8'd1, 8'd1});
    end
    @(negedge clk);
  endtask

  // mode 0: in_valid held, 1: toggled, 2: random. abort_k >= 0 asserts rst at that shift index.
  task automatic run_frame(input int mode, input bit noise, input int abort_k);
    int n;
    bit v, aborted;
    dut_wins = 0; dut_fd = 0; dut_pads = 0; dut_feeds = 0;
    aborted = 0;
    step(0, 1, 0);
    n = 0;
    while (m_active && n < 2000) begin
      case (mode)
        0: v = 1;
        1: v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (abort_k >= 0 && m_k == abort_k) begin
        step(1, 0, 1);
        aborted = 1;
        check("abort_ctr_col", ctr_col, 0);
        check("abort_ctr_row", ctr_row, 0);
      end else begin
        step(0, noise ? 1'($urandom_range(0, 3) == 0) : 1'b0, v);
      end
      n++;
    end
    check("frame_timeout", n < 2000, 1);
    if (!aborted) begin
      check("win_count", dut_wins, NWIN);
      check("frame_done_count", dut_fd, 1);
      check("flush_count", dut_pads, W + 1);
      check("feed_count", dut_feeds, NFEED);
      check("queue_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0;
    @(negedge clk);
    step(1, 0, 0);
    step(1, 1, 1);
    check("reset_ctr_col", ctr_col, 0);
    check("reset_ctr_row", ctr_row, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    run_frame(0, 0, -1);
    run_frame(1, 0, -1);
    run_frame(0, 0, 20);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    run_frame(0, 0, -1);
    run_frame(0, 1, -1);
    for (int i = 0; i < 4; i++) run_frame(2, 1, -1);
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
